// File: rtl/cpu_tx_fifo_periph_pkg.sv
// Register addresses and bit positions shared by the TX FIFO peripheral and its users.
package cpu_tx_fifo_pkg;

  localparam logic [3:0] ADDR_DATA   = 4'h0;
  localparam logic [3:0] ADDR_STATUS = 4'h1;
  localparam logic [3:0] ADDR_COUNT  = 4'h2;
  localparam logic [3:0] ADDR_CTRL   = 4'h3;
  localparam logic [3:0] ADDR_LO_THR = 4'h4;
  localparam logic [3:0] ADDR_ID     = 4'h5;

  localparam int ST_EMPTY = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_LOW   = 2;
  localparam int ST_OVF   = 3;

  localparam int CTRL_EN    = 0;
  localparam int CTRL_IE    = 1;
  localparam int CTRL_FLUSH = 2;

endpackage

// File: rtl/cpu_tx_fifo_periph_if.sv
// Simple CPU register bus: one access per cycle with CS high, registered read data.
interface cpu_if;
  logic       CS;
  logic       Rd_Wr;
  logic [3:0] Addr;
  logic [7:0] DataIn;
  logic [7:0] DataOut;

  modport master (output CS, Rd_Wr, Addr, DataIn, input DataOut);
  modport slave  (input CS, Rd_Wr, Addr, DataIn, output DataOut);
endinterface

// File: rtl/cpu_tx_fifo_periph_sync_fifo.sv
// First-word-fall-through synchronous FIFO; caller guarantees push only when room and pop only when data.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wrData,
  output logic [WIDTH-1:0]         rdData,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wrPtr;
  logic [AW-1:0]    rdPtr;

  // Storage is not reset so it can map onto RAM primitives.
  always_ff @(posedge clk) begin
    if (push) mem[wrPtr] <= wrData;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  assign rdData = mem[rdPtr];
  assign full   = (count == (AW+1)'(DEPTH));
  assign empty  = (count == '0);
endmodule

// File: rtl/cpu_tx_fifo_periph.sv
// CPU-writable transmit FIFO drained by a valid/ready byte stream, with status and low-water irq.
module cpu_tx_fifo_periph
  import cpu_tx_fifo_pkg::*;
#(
  parameter int         DEPTH      = 16,
  parameter logic [7:0] LO_THR_RST = 8'd4,
  parameter logic [7:0] ID_VAL     = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  cpu_if.slave       bus,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       irq
);
  localparam int AW = $clog2(DEPTH);

  logic         en;
  logic         ie;
  logic         ovf;
  logic [7:0]   loThr;
  logic [7:0]   dataOut;
  logic [AW:0]  count;
  logic         full;
  logic         empty;
  logic         wrAcc;
  logic         rdAcc;
  logic         dataWr;
  logic         push;
  logic         pop;
  logic         flush;
  logic         low;
  logic [7:0]   countByte;
  logic [7:0]   status;
  logic [7:0]   rdVal;

  assign wrAcc     = bus.CS && !bus.Rd_Wr;
  assign rdAcc     = bus.CS && bus.Rd_Wr;
  assign dataWr    = wrAcc && (bus.Addr == ADDR_DATA) && en;
  assign out_valid = en && !empty;
  assign pop       = out_valid && out_ready;
  // A full FIFO still accepts a byte when the consumer frees a slot in the same cycle.
  assign push      = dataWr && (!full || pop);
  assign flush     = wrAcc && (bus.Addr == ADDR_CTRL) && bus.DataIn[CTRL_FLUSH];
  assign countByte = 8'(count);
  assign low       = (countByte <= loThr);

  sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) fifo (
    .clk    (clk),
    .rst    (rst),
    .push   (push),
    .pop    (pop),
    .flush  (flush),
    .wrData (bus.DataIn),
    .rdData (out_data),
    .count  (count),
    .full   (full),
    .empty  (empty)
  );

  always_comb begin
    status           = '0;
    status[ST_EMPTY] = empty;
    status[ST_FULL]  = full;
    status[ST_LOW]   = low;
    status[ST_OVF]   = ovf;
  end

  always_comb begin
    rdVal = 8'h00;
    case (bus.Addr)
      ADDR_STATUS: rdVal = status;
      ADDR_COUNT:  rdVal = countByte;
      ADDR_CTRL:   rdVal = {6'b0, ie, en};
      ADDR_LO_THR: rdVal = loThr;
      ADDR_ID:     rdVal = ID_VAL;
      default:     rdVal = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      en      <= 1'b0;
      ie      <= 1'b0;
      ovf     <= 1'b0;
      loThr   <= LO_THR_RST;
      dataOut <= 8'h00;
      irq     <= 1'b0;
    end else begin
      if (rdAcc) dataOut <= rdVal;
      if (wrAcc && (bus.Addr == ADDR_CTRL)) begin
        en <= bus.DataIn[CTRL_EN];
        ie <= bus.DataIn[CTRL_IE];
      end
      if (wrAcc && (bus.Addr == ADDR_LO_THR)) loThr <= bus.DataIn;
      if (dataWr && !push)
        ovf <= 1'b1;
      else if (wrAcc && (bus.Addr == ADDR_STATUS) && bus.DataIn[ST_OVF])
        ovf <= 1'b0;
      irq <= ie && (low || ovf);
    end
  end

  assign bus.DataOut = dataOut;
endmodule

// File: tb/tb_cpu_tx_fifo_periph.sv
// Scoreboard bench: bytes pushed by the CPU are queued and matched against the output stream.
module tb_cpu_tx_fifo_periph;
  import cpu_tx_fifo_pkg::*;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       out_ready = 1'b0;
  logic       out_valid;
  logic       irq;
  logic [7:0] out_data;

  cpu_if bus();

  cpu_tx_fifo_periph #(.DEPTH(DEPTH), .LO_THR_RST(8'd4), .ID_VAL(8'hA5)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  int         vectors = 0;
  int         miscompares = 0;
  logic [7:0] sb [$];
  logic       enModel = 1'b0;
  logic       ovfModel = 1'b0;
  int         loThrModel = 4;
  logic [7:0] monExp;

  task automatic checkVal(input string tag, input logic [7:0] got, input logic [7:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end else begin
      $display("ok   %s: %02h", tag, got);
    end
  endtask

  // Handshakes seen at the falling edge complete at the next rising edge.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checkVal("stream_valid", {7'b0, out_valid}, 8'h00);
      end else begin
        monExp = sb.pop_front();
        checkVal("stream_data", out_data, monExp);
      end
    end
  end

  task automatic busWrite(input logic [3:0] a, input logic [7:0] d, input logic rdy = 1'b0);
    logic popNow;
    @(posedge clk); #1;
    bus.CS = 1'b1; bus.Rd_Wr = 1'b0; bus.Addr = a; bus.DataIn = d; out_ready = rdy;
    popNow = rdy && enModel && (sb.size() > 0);
    if (a == ADDR_DATA && enModel) begin
      if (sb.size() < DEPTH || popNow) sb.push_back(d);
      else ovfModel = 1'b1;
    end
    if (a == ADDR_STATUS && d[3]) ovfModel = 1'b0;
    @(posedge clk); #1;
    bus.CS = 1'b0; out_ready = 1'b0;
    if (a == ADDR_CTRL) begin
      enModel = d[0];
      if (d[2]) sb.delete();
    end
    if (a == ADDR_LO_THR) loThrModel = int'(d);
  endtask

  task automatic busRead(input logic [3:0] a, input logic [7:0] exp, input string tag);
    @(posedge clk); #1;
    bus.CS = 1'b1; bus.Rd_Wr = 1'b1; bus.Addr = a; bus.DataIn = 8'h5A;
    @(posedge clk); #1;
    bus.CS = 1'b0;
    checkVal(tag, bus.DataOut, exp);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    @(posedge clk); #1;
    out_ready = 1'b1;
    while (sb.size() > 0 && n < 64) begin
      @(posedge clk); #1;
      n++;
    end
    out_ready = 1'b0;
    checkVal(tag, 8'(sb.size()), 8'h00);
  endtask

  initial begin
    bus.CS = 1'b0; bus.Rd_Wr = 1'b0; bus.Addr = 4'h0; bus.DataIn = 8'h00;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state and register map
    checkVal("rst_dataout", bus.DataOut, 8'h00);
    checkVal("rst_irq", {7'b0, irq}, 8'h00);
    checkVal("rst_valid", {7'b0, out_valid}, 8'h00);
    busRead(ADDR_STATUS, 8'h05, "rst_status");
    busRead(ADDR_COUNT,  8'h00, "rst_count");
    busRead(ADDR_CTRL,   8'h00, "rst_ctrl");
    busRead(ADDR_LO_THR, 8'h04, "rst_lothr");
    busRead(ADDR_ID,     8'hA5, "id");
    busWrite(ADDR_LO_THR, 8'h02);
    checkVal("dataout_hold", bus.DataOut, 8'hA5);
    busRead(ADDR_DATA, 8'h00, "data_read");
    busRead(4'hF,      8'h00, "unmapped");
    busWrite(ADDR_DATA, 8'h99);
    busRead(ADDR_STATUS, 8'h05, "dis_status");

    // Basic push then stream out
    busWrite(ADDR_CTRL, 8'h01);
    busWrite(ADDR_DATA, 8'h11);
    busWrite(ADDR_DATA, 8'h22);
    busWrite(ADDR_DATA, 8'h33);
    busRead(ADDR_COUNT,  8'h03, "t2_count");
    busRead(ADDR_STATUS, 8'h00, "t2_status");
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkVal("t2_valid", {7'b0, out_valid}, 8'h01);
      @(posedge clk); #1;
    end
    checkVal("t2_empty", {7'b0, out_valid}, 8'h00);
    out_ready = 1'b0;

    // Fill to full, overflow, clear ovf
    for (int i = 0; i < 17; i++) busWrite(ADDR_DATA, 8'h40 + 8'(i));
    busRead(ADDR_COUNT,  8'h10, "t3_count");
    busRead(ADDR_STATUS, 8'h0A, "t3_status");
    busWrite(ADDR_STATUS, 8'h08);
    busRead(ADDR_STATUS, 8'h02, "t3_w1c");

    // Push into a full FIFO while popping, then wrap the pointers
    busWrite(ADDR_DATA, 8'hC0, 1'b1);
    busRead(ADDR_COUNT,  8'h10, "t4_count");
    busRead(ADDR_STATUS, 8'h02, "t4_status");
    for (int i = 0; i < 23; i++) busWrite(ADDR_DATA, 8'hC1 + 8'(i), 1'b1);
    drain("t4_drain");
    busRead(ADDR_COUNT, 8'h00, "t4_count0");

    // Low-water and overflow interrupt
    busWrite(ADDR_DATA, 8'hA1);
    busWrite(ADDR_DATA, 8'hA2);
    busWrite(ADDR_DATA, 8'hA3);
    busWrite(ADDR_CTRL, 8'h03);
    @(posedge clk); #1;
    checkVal("t5_irq_hi_cnt", {7'b0, irq}, 8'h00);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkVal("t5_irq_lag", {7'b0, irq}, 8'h00);
    @(posedge clk); #1;
    checkVal("t5_irq_low", {7'b0, irq}, 8'h01);
    busWrite(ADDR_DATA, 8'hA4);
    @(posedge clk); #1;
    checkVal("t5_irq_clr", {7'b0, irq}, 8'h00);
    for (int i = 0; i < 14; i++) busWrite(ADDR_DATA, 8'hD0 + 8'(i));
    @(posedge clk); #1;
    checkVal("t5_irq_ovf", {7'b0, irq}, 8'h01);
    busWrite(ADDR_CTRL, 8'h01);
    @(posedge clk); #1;
    checkVal("t5_irq_ie0", {7'b0, irq}, 8'h00);
    busRead(ADDR_STATUS, 8'h0A, "t5_status");

    // Flush, including a handshake in the flush cycle
    busWrite(ADDR_CTRL, 8'h05);
    busRead(ADDR_COUNT, 8'h00, "t6_flush_full");
    for (int i = 0; i < 5; i++) busWrite(ADDR_DATA, 8'hB0 + 8'(i));
    busRead(ADDR_COUNT, 8'h05, "t6_count5");
    busWrite(ADDR_CTRL, 8'h05, 1'b1);
    checkVal("t6_valid", {7'b0, out_valid}, 8'h00);
    busRead(ADDR_COUNT,  8'h00, "t6_count0");
    busRead(ADDR_CTRL,   8'h01, "t6_ctrl");
    busRead(ADDR_STATUS, 8'h0D, "t6_status");

    // Reset in the middle of streaming
    busWrite(ADDR_CTRL, 8'h03);
    for (int i = 0; i < 4; i++) busWrite(ADDR_DATA, 8'hE0 + 8'(i));
    busRead(ADDR_LO_THR, 8'h02, "t6_lothr");
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b0;
    sb.delete();
    enModel = 1'b0; ovfModel = 1'b0; loThrModel = 4;
    checkVal("rst2_dataout", bus.DataOut, 8'h00);
    checkVal("rst2_irq", {7'b0, irq}, 8'h00);
    checkVal("rst2_valid", {7'b0, out_valid}, 8'h00);
    busRead(ADDR_STATUS, 8'h05, "rst2_status");
    busRead(ADDR_COUNT,  8'h00, "rst2_count");
    busRead(ADDR_CTRL,   8'h00, "rst2_ctrl");
    busRead(ADDR_LO_THR, 8'h04, "rst2_lothr");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end
endmodule
